// File: rtl/level_sequencer_if.sv
// level_sequencer_if: player/random inputs and target/status outputs of the game-flow controller
interface level_sequencer_if;
  logic        enter_pressed;
  logic        player_at_target;
  logic        player_dead;
  logic [4:0]  rand_col;
  logic [4:0]  rand_row;
  logic [1:0]  level;
  logic [10:0] target_x;
  logic [10:0] target_y;
  logic        target_kind;
  logic        target_valid;
  logic        level_start;
  logic        game_won;
  logic        game_over;
  modport master (
    output enter_pressed, player_at_target, player_dead, rand_col, rand_row,
    input  level, target_x, target_y, target_kind, target_valid, level_start, game_won, game_over
  );
  modport slave (
    input  enter_pressed, player_at_target, player_dead, rand_col, rand_row,
    output level, target_x, target_y, target_kind, target_valid, level_start, game_won, game_over
  );
endinterface

// File: rtl/level_sequencer.sv
// level_sequencer: draws door/idol cells, sequences two levels and flags win/lose
module level_sequencer #(
  parameter int NUM_COLS     = 9,
  parameter int NUM_ROWS     = 6,
  parameter int CELL_SIZE    = 64,
  parameter int X_OFFSET     = 15,
  parameter int Y_OFFSET     = 48,
  parameter int MAX_RETRY    = 31,
  parameter int CLEAR_CYCLES = 50
) (
  input logic              clk,
  input logic              reset,
  level_sequencer_if.slave bus
);
  localparam int CW = $clog2(MAX_RETRY + 1);
  localparam int LW = $clog2(CLEAR_CYCLES);
  typedef enum logic [2:0] {S_IDLE, S_DRAW1, S_DRAW2, S_PLAY, S_CLEAR, S_WIN, S_LOSE} state_t;
  state_t          r_state, w_nxt;
  logic            r_enter_q;
  logic [CW-1:0]   r_cnt;
  logic [LW-1:0]   r_clr;
  logic [4:0]      r_c1_col, r_c1_row, r_c2_col, r_c2_row;
  logic [1:0]      r_level;
  logic [10:0]     r_tx, r_ty;
  logic            r_kind, r_level_start;
  logic            w_edge, w_ok1, w_ok2, w_max, w_clr_done;
  function automatic logic [10:0] px(input logic [4:0] v, input int off);
    return 11'(v) * 11'(CELL_SIZE) + 11'(off);
  endfunction
  assign w_edge     = bus.enter_pressed & ~r_enter_q;
  assign w_ok1      = (bus.rand_col < 5'(NUM_COLS)) && (bus.rand_row < 5'(NUM_ROWS));
  assign w_ok2      = w_ok1 && ({bus.rand_col, bus.rand_row} != {r_c1_col, r_c1_row});
  assign w_max      = r_cnt == CW'(MAX_RETRY);
  assign w_clr_done = r_clr == '0;
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= S_IDLE;
    else r_state <= w_nxt;
  // next-state: a dead player beats reaching the target; CLEAR ignores death
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:  w_nxt = w_edge ? S_DRAW1 : S_IDLE;
      S_DRAW1: w_nxt = (w_ok1 || w_max) ? S_DRAW2 : S_DRAW1;
      S_DRAW2: w_nxt = (w_ok2 || w_max) ? S_PLAY : S_DRAW2;
      S_PLAY:  w_nxt = bus.player_dead ? S_LOSE : bus.player_at_target ? S_CLEAR : S_PLAY;
      S_CLEAR: w_nxt = !w_clr_done ? S_CLEAR : (r_level == 2'd2) ? S_WIN : S_PLAY;
      S_WIN,
      S_LOSE:  w_nxt = w_edge ? S_IDLE : r_state;
      default: w_nxt = S_IDLE;
    endcase
  end
  // datapath: cell draws, counters and target registers loaded on the edge entering PLAY
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_enter_q     <= 1'b0;
      r_cnt         <= '0;
      r_clr         <= '0;
      r_c1_col      <= '0;
      r_c1_row      <= '0;
      r_c2_col      <= '0;
      r_c2_row      <= '0;
      r_level       <= '0;
      r_tx          <= '0;
      r_ty          <= '0;
      r_kind        <= 1'b0;
      r_level_start <= 1'b0;
    end else begin
      r_enter_q     <= bus.enter_pressed;
      r_level_start <= (w_nxt == S_PLAY) && (r_state != S_PLAY);
      case (r_state)
        S_IDLE: r_cnt <= '0;
        S_DRAW1: begin
          r_cnt <= (w_ok1 || w_max) ? '0 : r_cnt + 1'b1;
          if (w_ok1) begin
            r_c1_col <= bus.rand_col;
            r_c1_row <= bus.rand_row;
          end else if (w_max) begin
            r_c1_col <= 5'd0;
            r_c1_row <= 5'd0;
          end
        end
        S_DRAW2: begin
          r_cnt <= (w_ok2 || w_max) ? '0 : r_cnt + 1'b1;
          if (w_ok2) begin
            r_c2_col <= bus.rand_col;
            r_c2_row <= bus.rand_row;
          end else if (w_max) begin
            r_c2_col <= 5'd1;
            r_c2_row <= 5'd0;
          end
          if (w_ok2 || w_max) begin
            r_level <= 2'd1;
            r_tx    <= px(r_c1_col, X_OFFSET);
            r_ty    <= px(r_c1_row, Y_OFFSET);
            r_kind  <= 1'b0;
          end
        end
        S_PLAY: if (!bus.player_dead && bus.player_at_target) r_clr <= LW'(CLEAR_CYCLES - 1);
        S_CLEAR:
          if (!w_clr_done) r_clr <= r_clr - 1'b1;
          else if (r_level != 2'd2) begin
            r_level <= 2'd2;
            r_tx    <= px(r_c2_col, X_OFFSET);
            r_ty    <= px(r_c2_row, Y_OFFSET);
            r_kind  <= 1'b1;
          end
        S_WIN,
        S_LOSE: if (w_edge) r_level <= 2'd0;
        default: ;
      endcase
    end
  assign bus.level        = r_level;
  assign bus.target_x     = r_tx;
  assign bus.target_y     = r_ty;
  assign bus.target_kind  = r_kind;
  assign bus.target_valid = r_state == S_PLAY;
  assign bus.level_start  = r_level_start;
  assign bus.game_won     = r_state == S_WIN;
  assign bus.game_over    = r_state == S_LOSE;
endmodule

// File: tb/tb_level_sequencer.sv
// tb_level_sequencer: directed vectors with hand-computed targets for level_sequencer
module tb_level_sequencer;
  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;
  int   n_start = 0;
  level_sequencer_if bus ();
  level_sequencer dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (bus.level_start) n_start++;
    end
  endtask
  task automatic rnd(input int c, input int r);
    bus.rand_col = 5'(c);
    bus.rand_row = 5'(r);
  endtask
  task automatic tgt(input string tag, input int lv, input int x, input int y, input int k);
    check({tag, "_valid"}, int'(bus.target_valid), 1);
    check({tag, "_level"}, int'(bus.level), lv);
    check({tag, "_x"}, int'(bus.target_x), x);
    check({tag, "_y"}, int'(bus.target_y), y);
    check({tag, "_kind"}, int'(bus.target_kind), k);
  endtask
  task automatic rst_outs(input string tag);
    check({tag, "_level"}, int'(bus.level), 0);
    check({tag, "_xy"}, int'({bus.target_x, bus.target_y}), 0);
    check({tag, "_flags"}, int'({bus.target_kind, bus.target_valid, bus.level_start, bus.game_won, bus.game_over}), 0);
  endtask
  initial begin
    reset = 1'b1;
    bus.enter_pressed = 1'b0;
    bus.player_at_target = 1'b0;
    bus.player_dead = 1'b0;
    rnd(0, 0);
    tick(2);
    rst_outs("reset");
    reset = 1'b0;
    tick();
    bus.enter_pressed = 1'b1;
    rnd(3, 2);
    tick(2);
    rnd(5, 4);
    tick();
    tgt("t1_play", 1, 207, 176, 0);
    check("t1_start", int'(bus.level_start), 1);
    tick(7);
    check("t1_held_start", n_start, 1);
    check("t1_held_level", int'(bus.level), 1);
    bus.enter_pressed = 1'b0;
    bus.player_at_target = 1'b1;
    tick();
    bus.player_at_target = 1'b0;
    bus.player_dead = 1'b1;
    tick();
    bus.player_dead = 1'b0;
    tick(47);
    check("t3_clear_valid", int'(bus.target_valid), 0);
    check("t3_clear_dead_ignored", int'(bus.game_over), 0);
    tick();
    check("t3_clear_last", int'(bus.target_valid), 0);
    tick();
    tgt("t3_l2", 2, 335, 304, 1);
    check("t3_start", n_start, 2);
    bus.player_at_target = 1'b1;
    tick();
    bus.player_at_target = 1'b0;
    tick(49);
    check("t4_not_won_yet", int'(bus.game_won), 0);
    tick();
    check("t4_won", int'(bus.game_won), 1);
    check("t4_won_valid", int'(bus.target_valid), 0);
    bus.enter_pressed = 1'b1;
    tick();
    check("t4_idle_level", int'(bus.level), 0);
    check("t4_idle_won", int'(bus.game_won), 0);
    check("t4_idle_valid", int'(bus.target_valid), 0);
    check("t4_hold_x", int'(bus.target_x), 335);
    bus.enter_pressed = 1'b0;
    tick();
    bus.enter_pressed = 1'b1;
    tick();
    rnd(12, 1);
    tick();
    rnd(2, 9);
    tick();
    check("t2_reject_valid", int'(bus.target_valid), 0);
    rnd(2, 1);
    tick();
    bus.enter_pressed = 1'b0;
    tick(31);
    check("t2_retry_valid", int'(bus.target_valid), 0);
    tick();
    tgt("t2_l1", 1, 143, 112, 0);
    bus.player_at_target = 1'b1;
    tick();
    bus.player_at_target = 1'b0;
    tick(50);
    tgt("t2_l2_forced", 2, 79, 48, 1);
    bus.player_dead = 1'b1;
    bus.player_at_target = 1'b1;
    tick();
    bus.player_dead = 1'b0;
    bus.player_at_target = 1'b0;
    check("t5_over", int'(bus.game_over), 1);
    check("t5_valid", int'(bus.target_valid), 0);
    check("t5_won", int'(bus.game_won), 0);
    tick(51);
    check("t5_still_over", int'(bus.game_over), 1);
    check("t5_level", int'(bus.level), 2);
    bus.enter_pressed = 1'b1;
    tick();
    check("t5_idle_over", int'(bus.game_over), 0);
    check("t5_idle_level", int'(bus.level), 0);
    bus.enter_pressed = 1'b0;
    tick();
    bus.enter_pressed = 1'b1;
    rnd(0, 0);
    tick(2);
    rnd(8, 5);
    tick();
    tgt("t6_l1", 1, 15, 48, 0);
    bus.enter_pressed = 1'b0;
    bus.player_at_target = 1'b1;
    tick();
    bus.player_at_target = 1'b0;
    tick(10);
    reset = 1'b1;
    tick();
    rst_outs("t6_rst_clear");
    reset = 1'b0;
    tick();
    bus.enter_pressed = 1'b1;
    rnd(4, 3);
    tick(2);
    tick(5);
    reset = 1'b1;
    bus.enter_pressed = 1'b0;
    tick();
    rst_outs("t6_rst_draw2");
    reset = 1'b0;
    tick();
    bus.enter_pressed = 1'b1;
    rnd(6, 5);
    tick(2);
    rnd(7, 0);
    tick();
    tgt("t6_fresh_l1", 1, 399, 368, 0);
    bus.enter_pressed = 1'b0;
    bus.player_at_target = 1'b1;
    tick();
    bus.player_at_target = 1'b0;
    tick(50);
    tgt("t6_fresh_l2", 2, 463, 48, 1);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
